mux4_rr_arbiter: RTL

Round-robin arbiter that shares one 4-to-1 multiplexer (`mux4to1`, select lines `s1`/`s0`) between four requesters. It registers a one-hot grant and drives the matching select code, so only the granted requester's data appears at the mux output `y`. A programmable hold limit forces rotation so a requester that keeps its request asserted cannot starve the others. It sits directly in front of `mux4to1`: `s1`/`s0` wire straight to the mux, and `d0`..`d3` come from requesters 0..3.

---
 rtl/mux4_rr_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter in front of a shared 4-to-1 multiplexer.
//               It registers a one-hot grant and the matching 2-bit select
//               code, so only the owner's data reaches the mux output.
//               A hold limit forces the grant to rotate when one requester
//               keeps its request asserted while others are waiting.
// Ports       : clk     - single clock, rising edge
//               rst     - asynchronous, active-high reset
//               req_i   - request vector, bit i = requester i (mux input di)
//               gnt_o   - registered one-hot grant, 0000 when idle
//               s1_o    - registered select MSB to the mux
//               s0_o    - registered select LSB to the mux
//               busy_o  - registered, high while a grant is active
// Parameters  : MAX_HOLD - max consecutive grant cycles while another
//               requester waits (1..255), 0 = unlimited
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic       s1_o,
    output logic       s0_o,
    output logic       busy_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Hold limit and the value at which the counter stops climbing.
    localparam logic [7:0] c_HOLD_LIMIT = 8'(MAX_HOLD);
    localparam bit         c_HOLD_EN    = (MAX_HOLD != 0);
    localparam logic [7:0] c_CNT_SAT    = c_HOLD_EN ? 8'(MAX_HOLD) : 8'd255;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic       busy_q,  busy_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] last_q,  last_d;

    // ------------------------------------------------------------------------
    // Round-robin search: scan upward starting just after 'after', wrapping
    // 3 -> 0. The index 'after' itself is visited last.
    // ------------------------------------------------------------------------
    function automatic logic [1:0] f_rr_pick(input logic [3:0] r,
                                             input logic [1:0] after);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = after;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = after + 2'(k);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Search inputs. In IDLE the scan starts after the last-served pointer
    // over the raw requests. In GRANT it starts after the current owner and
    // the owner is masked out, so a releasing or rotated-out owner is never
    // re-granted on the same edge.
    // ------------------------------------------------------------------------
    logic [3:0] w_others;
    logic       w_others_any;
    logic       w_owner_req;
    logic [3:0] w_search_src;
    logic [1:0] w_search_after;
    logic [1:0] w_win_idx;
    logic       w_hold_hit;

    assign w_others       = req_i & ~gnt_q;
    assign w_others_any   = |w_others;
    assign w_owner_req    = req_i[sel_q];
    assign w_search_src   = (state_q == ST_IDLE) ? req_i  : w_others;
    assign w_search_after = (state_q == ST_IDLE) ? last_q : sel_q;
    assign w_win_idx      = f_rr_pick(w_search_src, w_search_after);
    assign w_hold_hit     = c_HOLD_EN && (cnt_q == c_HOLD_LIMIT);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i != 4'b0000) begin
                    state_d = ST_GRANT;
                    gnt_d   = 4'b0001 << w_win_idx;
                    sel_d   = w_win_idx;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd1;
                end
            end

            ST_GRANT: begin
                if (!w_owner_req) begin
                    // Owner released: hand over without an idle bubble.
                    last_d = sel_q;
                    if (w_others_any) begin
                        gnt_d = 4'b0001 << w_win_idx;
                        sel_d = w_win_idx;
                        cnt_d = 8'd1;
                    end else begin
                        // Select keeps the old index so the mux does not glitch.
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end else if (w_others_any && w_hold_hit) begin
                    // Forced rotation away from a long-holding owner.
                    last_d = sel_q;
                    gnt_d  = 4'b0001 << w_win_idx;
                    sel_d  = w_win_idx;
                    cnt_d  = 8'd1;
                end else if (cnt_q != c_CNT_SAT) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers (all outputs come straight from here)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
            last_q  <= 2'd3;   // requester 0 wins first after reset
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign s1_o   = sel_q[1];
    assign s0_o   = sel_q[0];
    assign busy_o = busy_q;

    // ------------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------------
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt_q));
    a_sel_matches : assert property (@(posedge clk) disable iff (rst)
        busy_q |-> gnt_q[sel_q]);
    a_busy_eq_gnt : assert property (@(posedge clk) disable iff (rst)
        busy_q == (gnt_q != 4'b0000));

endmodule
`default_nettype wire
